// File: rtl/tdc_meas_ctrl.sv
// rtl/tdc_meas_ctrl.sv - measurement sequencer for the multistep ring-oscillator TDC
// Clears/arms the TDC, counts coarse cycles until hit or timeout, settles, captures fine code.
module tdc_meas_ctrl #(
  parameter int CODE_W     = 6,
  parameter int CNT_W      = 8,
  parameter int ARM_CYC    = 2,
  parameter int SETTLE_CYC = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              meas_req,
  output logic              meas_busy,
  input  logic              hit,
  output logic              tdc_start,
  output logic              tdc_stop,
  input  logic [CODE_W-1:0] tdc_code,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CODE_W-1:0] res_code,
  output logic [CNT_W-1:0]  res_coarse,
  output logic              res_timeout
);

  localparam int PH_MAX = (ARM_CYC > SETTLE_CYC) ? ARM_CYC : SETTLE_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    RUN     = 3'd2,
    SETTLE  = 3'd3,
    CAPTURE = 3'd4,
    OUT     = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [PH_W-1:0]   phase;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  lat_coarse;
  logic              lat_to;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (meas_req) state_nxt = ARM;
      ARM:     if (phase == PH_W'(ARM_CYC - 1)) state_nxt = RUN;
      RUN:     if (hit || (cnt == CNT_W'(TIMEOUT - 1))) state_nxt = SETTLE;
      SETTLE:  if (phase == PH_W'(SETTLE_CYC - 1)) state_nxt = CAPTURE;
      CAPTURE: state_nxt = OUT;
      OUT:     if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      meas_busy <= 1'b0;
      tdc_start <= 1'b0;
      tdc_stop  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      meas_busy <= (state_nxt != IDLE);
      tdc_start <= (state_nxt == RUN) || (state_nxt == SETTLE) || (state_nxt == CAPTURE);
      tdc_stop  <= (state_nxt == SETTLE) || (state_nxt == CAPTURE);
      res_valid <= (state_nxt == OUT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase       <= '0;
      cnt         <= '0;
      lat_coarse  <= '0;
      lat_to      <= 1'b0;
      res_code    <= '0;
      res_coarse  <= '0;
      res_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: phase <= '0;
        ARM: begin
          phase <= phase + 1'b1;
          cnt   <= '0;
        end
        RUN: begin
          // A hit on the last RUN cycle still counts as a hit, not a timeout.
          if (state_nxt == SETTLE) begin
            lat_coarse <= cnt;
            lat_to     <= ~hit;
            phase      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETTLE: phase <= phase + 1'b1;
        CAPTURE: begin
          res_code    <= tdc_code;
          res_coarse  <= lat_coarse;
          res_timeout <= lat_to;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// tb/tb_tdc_meas_ctrl.sv - scoreboard bench for tdc_meas_ctrl
// Stimulus pushes expected results; a negedge monitor pops them on each handshake.
module tb_tdc_meas_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       meas_req = 1'b0;
  logic       meas_busy;
  logic       hit = 1'b0;
  logic       tdc_start;
  logic       tdc_stop;
  logic [5:0] tdc_code = 6'd0;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [5:0] res_code;
  logic [7:0] res_coarse;
  logic       res_timeout;

  tdc_meas_ctrl dut (
    .clk(clk), .rst(rst), .meas_req(meas_req), .meas_busy(meas_busy),
    .hit(hit), .tdc_start(tdc_start), .tdc_stop(tdc_stop), .tdc_code(tdc_code),
    .res_valid(res_valid), .res_ready(res_ready), .res_code(res_code),
    .res_coarse(res_coarse), .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  typedef struct { logic [5:0] code; logic [7:0] coarse; logic to; } exp_t;
  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t_req, t_start, t_stop, t_valid;
  logic prev_start = 1'b0, prev_stop = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tdc_start && !prev_start) t_start = cyc;
    if (tdc_stop && !prev_stop) t_stop = cyc;
    prev_start = tdc_start;
    prev_stop  = tdc_stop;
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_code", int'(res_code), int'(e.code));
        chk("res_coarse", int'(res_coarse), int'(e.coarse));
        chk("res_timeout", int'(res_timeout), int'(e.to));
      end
    end
  end

  // Caller is at a negedge; req is sampled on the coming posedge.
  task automatic issue_req(input logic [5:0] code, input logic [7:0] coarse, input logic to);
    exp_t e;
    e.code = code; e.coarse = coarse; e.to = to;
    exp_q.push_back(e);
    tdc_code = code;
    meas_req = 1'b1;
    t_req = cyc + 1;
    @(negedge clk);
    meas_req = 1'b0;
  endtask

  // n < 0 means no hit at all.
  task automatic drive_hit(input int n);
    bit got = 0;
    for (int i = 0; i < 50; i++) begin
      if (tdc_start) begin got = 1; break; end
      @(negedge clk);
    end
    chk("wait_start", int'(got), 1);
    if (n >= 0) begin
      repeat (n) @(negedge clk);
      hit = 1'b1;
      @(negedge clk);
      hit = 1'b0;
    end
  endtask

  task automatic wait_valid();
    bit got = 0;
    for (int i = 0; i < 200; i++) begin
      if (res_valid) begin got = 1; break; end
      @(negedge clk);
    end
    chk("wait_valid", int'(got), 1);
    t_valid = cyc;
  endtask

  task automatic measure(input logic [5:0] code, input int n, input logic [7:0] coarse,
                         input logic to, input int runlen);
    @(negedge clk);
    issue_req(code, coarse, to);
    chk("busy_after_req", int'(meas_busy), 1);
    drive_hit(n);
    wait_valid();
    chk("valid_latency", t_valid - t_req, 2 + runlen + 4 + 1);
    chk("start_to_stop", t_stop - t_start, runlen);
    @(negedge clk);
    chk("valid_drops", int'(res_valid), 0);
    chk("idle_busy", int'(meas_busy), 0);
  endtask

  initial begin
    logic [5:0] hc;
    logic [7:0] hco;
    logic       hto;
    bit         seen;

    rst = 1'b1;
    meas_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_busy", int'(meas_busy), 0);
      chk("rst_outs", int'({tdc_start, tdc_stop, res_valid, res_timeout}), 0);
      chk("rst_res", int'({res_code, res_coarse}), 0);
    end
    rst = 1'b0;
    meas_req = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", int'(meas_busy), 0);

    measure(6'b010110, 5, 8'd5, 1'b0, 6);
    measure(6'b111000, -1, 8'd63, 1'b1, 64);
    measure(6'b000111, 63, 8'd63, 1'b0, 64);
    measure(6'b110011, 0, 8'd0, 1'b0, 1);

    // Backpressure: result must stay put while hit/meas_req are toggled.
    res_ready = 1'b0;
    @(negedge clk);
    issue_req(6'b101010, 8'd2, 1'b0);
    drive_hit(2);
    wait_valid();
    hc = res_code; hco = res_coarse; hto = res_timeout;
    chk("bp_code", int'(hc), 6'b101010);
    for (int i = 0; i < 10; i++) begin
      hit = i[0];
      meas_req = ~i[0];
      tdc_code = 6'(i);
      @(negedge clk);
      chk("bp_valid", int'(res_valid), 1);
      chk("bp_stable", int'({res_code, res_coarse, res_timeout}), int'({hc, hco, hto}));
      chk("bp_pins", int'({tdc_start, tdc_stop}), 0);
    end
    hit = 1'b0;
    meas_req = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_done_valid", int'(res_valid), 0);
    chk("bp_done_busy", int'(meas_busy), 0);
    chk("bp_queue_empty", exp_q.size(), 0);
    issue_req(6'b011001, 8'd3, 1'b0);
    chk("bp_next_arm", int'(meas_busy), 1);
    chk("bp_next_pins", int'({tdc_start, tdc_stop}), 0);
    drive_hit(3);
    wait_valid();
    chk("bp_next_latency", t_valid - t_req, 2 + 4 + 4 + 1);
    @(negedge clk);

    // Reset in SETTLE cycle 2 discards the measurement.
    exp_t_drop();
    drive_hit(1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (tdc_stop) begin seen = 1; break; end
      @(negedge clk);
    end
    chk("wait_stop", int'(seen), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_pins", int'({tdc_start, tdc_stop}), 0);
    chk("midrst_busy", int'(meas_busy), 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid) seen = 1;
    end
    chk("midrst_no_valid", int'(seen), 0);
    measure(6'b100001, 7, 8'd7, 1'b0, 8);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Request whose result is expected to be discarded, so nothing is queued.
  task automatic exp_t_drop();
    tdc_code = 6'b111111;
    meas_req = 1'b1;
    @(negedge clk);
    meas_req = 1'b0;
  endtask

endmodule
